note_seq_ctrl: RTL and testbench

NOTE_SEQ_CTRL -- requirements
Module: note_seq_ctrl

---
 rtl/note_ctrl_pkg.sv | 30 +++
 rtl/note_fifo.sv | 61 ++++++
 rtl/note_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_note_seq_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/note_ctrl_pkg.sv
// Shared constants, state encoding and output bundle for the note sequencer.
// Pure definitions: no logic, no latency, no flow control.
package note_ctrl_pkg;

  localparam logic [5:0]  NOTE_NONE  = 6'd0;
  localparam logic [23:0] COLOR_NEW  = 24'h00FF00;
  localparam logic [23:0] COLOR_HOLD = 24'hFFFFFF;
  localparam logic [23:0] COLOR_OFF  = 24'h000000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    WAIT = 2'd2
  } state_t;

  // Everything the note renderer sees, registered as one word.
  typedef struct packed {
    logic [5:0]  note;
    logic [23:0] color;
    logic        disp_en;
  } disp_t;

  // Counter width wide enough for the larger of the two frame limits.
  function automatic int cnt_width(input int hold_frames, input int idle_frames);
    int m;
    m = (hold_frames > idle_frames) ? hold_frames : idle_frames;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/note_fifo.sv
// Note event FIFO, registered storage with no fall-through: data pushed this cycle is poppable next cycle.
// push is ignored when full, pop when empty; flush empties it on the next edge and wins over push/pop.
module note_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign pop_dat = mem[rd_ptr];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/note_seq_ctrl.sv
// Frame-paced note display sequencer: each note is shown, held, then blanked; one-cycle latency from frame_start.
// ev_ready = !full && !clear; queued notes wait in the FIFO until the current note's hold time has expired.
module note_seq_ctrl
  import note_ctrl_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int IDLE_FRAMES = 120,
  parameter int DEPTH       = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   clear,
  input  logic                   ev_valid,
  input  logic [5:0]             ev_note,
  output logic                   ev_ready,
  output logic [5:0]             note,
  output logic [23:0]            color,
  output logic                   disp_en,
  output logic [$clog2(DEPTH):0] level
);

  localparam int              CNT_W     = cnt_width(HOLD_FRAMES, IDLE_FRAMES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_FRAMES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt, hold_d;
  logic [CNT_W-1:0] idle_cnt, idle_d;
  disp_t            disp_q, disp_d;
  logic [5:0]       note_d;

  logic [1:0] rst_sync;
  logic       run;
  logic       frame_tick;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic [5:0] fifo_dat;

  // Release from reset is re-timed so the FSM stays put for two edges after deassertion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign run = rst_sync[1];

  assign ev_ready   = !full && !clear;
  assign push       = ev_valid && ev_ready;
  assign frame_tick = frame_start && run && !clear;

  note_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (6)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (clear),
    .push     (push),
    .push_dat (ev_note),
    .pop      (pop),
    .pop_dat  (fifo_dat),
    .full     (full),
    .empty    (empty),
    .level    (level)
  );

  always_comb begin
    state_d = state_q;
    hold_d  = hold_cnt;
    idle_d  = idle_cnt;
    note_d  = disp_q.note;
    pop     = 1'b0;

    if (clear) begin
      state_d = IDLE;
      hold_d  = '0;
      idle_d  = '0;
      note_d  = NOTE_NONE;
    end else if (frame_tick) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            note_d  = fifo_dat;
            hold_d  = '0;
            state_d = SHOW;
          end
        end
        SHOW: begin
          // A queued note never cuts the minimum hold short.
          if (hold_cnt == HOLD_LAST) begin
            state_d = WAIT;
            idle_d  = '0;
          end else begin
            hold_d = hold_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (!empty) begin
            pop     = 1'b1;
            note_d  = fifo_dat;
            hold_d  = '0;
            state_d = SHOW;
          end else if (idle_cnt == IDLE_LAST) begin
            state_d = IDLE;
            note_d  = NOTE_NONE;
          end else begin
            idle_d = idle_cnt + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          note_d  = NOTE_NONE;
        end
      endcase
    end
  end

  // Renderer outputs are decoded from the next state so they land together with it.
  always_comb begin
    disp_d.note = note_d;
    case (state_d)
      SHOW: begin
        disp_d.color   = COLOR_NEW;
        disp_d.disp_en = 1'b1;
      end
      WAIT: begin
        disp_d.color   = COLOR_HOLD;
        disp_d.disp_en = 1'b1;
      end
      default: begin
        disp_d.color   = COLOR_OFF;
        disp_d.disp_en = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      hold_cnt <= '0;
      idle_cnt <= '0;
      disp_q   <= '{note: NOTE_NONE, color: COLOR_OFF, disp_en: 1'b0};
    end else begin
      state_q  <= state_d;
      hold_cnt <= hold_d;
      idle_cnt <= idle_d;
      disp_q   <= disp_d;
    end
  end

  assign note    = disp_q.note;
  assign color   = disp_q.color;
  assign disp_en = disp_q.disp_en;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Directed and randomized checks of note_seq_ctrl against a frame-age reference model.
module tb_note_seq_ctrl;

  localparam int HOLD  = 3;
  localparam int IDLEF = 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       clear = 1'b0;
  logic       ev_valid = 1'b0;
  logic [5:0] ev_note = 6'd0;
  logic       ev_ready;
  logic [5:0] note;
  logic [23:0] color;
  logic       disp_en;
  logic [2:0] level;

  int vecs = 0;
  int errs = 0;

  // Reference model: queue of pending notes, plus age of the note on screen in frames.
  int  q[$];
  bit  m_active = 1'b0;
  int  m_note = 0;
  int  m_age = 0;

  note_seq_ctrl #(
    .HOLD_FRAMES (HOLD),
    .IDLE_FRAMES (IDLEF),
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .clear       (clear),
    .ev_valid    (ev_valid),
    .ev_note     (ev_note),
    .ev_ready    (ev_ready),
    .note        (note),
    .color       (color),
    .disp_en     (disp_en),
    .level       (level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_active = 1'b0;
    m_note   = 0;
    m_age    = 0;
  endtask

  task automatic model_frame();
    if (!m_active) begin
      if (q.size() > 0) begin
        m_note   = q.pop_front();
        m_active = 1'b1;
        m_age    = 0;
      end
    end else if (m_age >= HOLD && q.size() > 0) begin
      m_note = q.pop_front();
      m_age  = 0;
    end else begin
      m_age++;
      if (m_age >= HOLD + IDLEF) begin
        m_active = 1'b0;
        m_note   = 0;
      end
    end
  endtask

  task automatic chk_outputs(input string tag);
    logic [23:0] exp_col;
    exp_col = !m_active ? 24'h000000 : (m_age < HOLD) ? 24'h00FF00 : 24'hFFFFFF;
    chk({tag, ".note"},  32'(note),    32'(m_active ? m_note : 0));
    chk({tag, ".color"}, 32'(color),   32'(exp_col));
    chk({tag, ".disp"},  32'(disp_en), 32'(m_active));
    chk({tag, ".level"}, 32'(level),   32'(q.size()));
  endtask

  // One clock cycle: inputs applied after a falling edge, outputs checked at the next falling edge.
  task automatic step(input bit fs, input bit clr, input bit v, input logic [5:0] nt);
    bit exp_rdy;
    bit pushed;
    frame_start = fs;
    clear       = clr;
    ev_valid    = v;
    ev_note     = nt;
    #1;
    exp_rdy = (q.size() < DEPTH) && !clr;
    chk("ev_ready", 32'(ev_ready), 32'(exp_rdy));
    pushed = v && exp_rdy;
    @(posedge clk);
    if (clr)     model_reset();
    else if (fs) model_frame();
    if (pushed)  q.push_back(int'(nt));
    @(negedge clk);
    chk_outputs("cyc");
  endtask

  task automatic frames(input int k);
    repeat (k) begin
      step(1'b1, 1'b0, 1'b0, 6'd0);
      step(1'b0, 1'b0, 1'b0, 6'd0);
    end
  endtask

  task automatic chk_blank(input string tag);
    chk({tag, ".note"},  32'(note),    32'd0);
    chk({tag, ".color"}, 32'(color),   32'h000000);
    chk({tag, ".disp"},  32'(disp_en), 32'd0);
    chk({tag, ".level"}, 32'(level),   32'd0);
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 6'd0);
  endtask

  initial begin
    // Power-on reset
    frame_start = 1'b0;
    clear       = 1'b0;
    ev_valid    = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk_blank("reset");
    chk("reset.rdy", 32'(ev_ready), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    reset_release();

    // First note appears one cycle after the popping frame_start
    step(1'b0, 1'b0, 1'b1, 6'd12);
    step(1'b1, 1'b0, 1'b0, 6'd0);
    chk("first.note",  32'(note),    32'd12);
    chk("first.color", 32'(color),   32'h00FF00);
    chk("first.disp",  32'(disp_en), 32'd1);
    step(1'b0, 1'b0, 1'b0, 6'd0);

    // Lone note: SHOW 3 frames, WAIT 2 frames, then blank
    for (int f = 2; f <= 6; f++) begin
      frames(1);
      chk("life.color", 32'(color),
          (f <= 3) ? 32'h00FF00 : (f <= 5) ? 32'hFFFFFF : 32'h000000);
      chk("life.disp", 32'(disp_en), (f <= 5) ? 32'd1 : 32'd0);
    end
    chk("life.note", 32'(note), 32'd0);

    // Back-to-back notes: second one never preempts the first's hold
    step(1'b0, 1'b0, 1'b1, 6'd12);
    step(1'b0, 1'b0, 1'b1, 6'd20);
    frames(1);
    chk("b2b.first", 32'(note), 32'd12);
    for (int k = 1; k <= 3; k++) begin
      frames(1);
      chk("b2b.hold", 32'(note), 32'd12);
    end
    frames(1);
    chk("b2b.second", 32'(note), 32'd20);
    frames(5);
    chk("b2b.blank", 32'(disp_en), 32'd0);

    // Fill past capacity, then one pop reopens the FIFO
    for (int i = 1; i <= 5; i++) step(1'b0, 1'b0, 1'b1, 6'(i));
    chk("full.level", 32'(level), 32'd4);
    chk("full.rdy",   32'(ev_ready), 32'd0);
    step(1'b1, 1'b0, 1'b1, 6'd5);
    chk("full.pop", 32'(note), 32'd1);
    chk("full.rdy_back", 32'(ev_ready), 32'd1);
    step(1'b0, 1'b0, 1'b1, 6'd5);
    step(1'b0, 1'b0, 1'b0, 6'd0);
    for (int idx = 2; idx <= 5; idx++) begin
      frames(4);
      chk("order", 32'(note), 32'(idx));
    end
    frames(5);
    chk("order.blank", 32'(disp_en), 32'd0);

    // Push on a frame_start into an empty FIFO waits for the next frame
    step(1'b1, 1'b0, 1'b1, 6'd33);
    chk("nobypass.disp",  32'(disp_en), 32'd0);
    chk("nobypass.level", 32'(level),   32'd1);
    frames(1);
    chk("nobypass.load", 32'(note), 32'd33);

    // Clear mid-SHOW with three queued, frame_start and an offer on the same cycle
    step(1'b0, 1'b0, 1'b1, 6'd7);
    step(1'b0, 1'b0, 1'b1, 6'd8);
    step(1'b0, 1'b0, 1'b1, 6'd9);
    chk("clr.pre_level", 32'(level), 32'd3);
    chk("clr.pre_disp",  32'(disp_en), 32'd1);
    step(1'b1, 1'b1, 1'b1, 6'd10);
    chk_blank("clr");
    frames(1);
    chk_blank("clr.after");

    // Reset mid-SHOW with three queued takes effect immediately
    step(1'b0, 1'b0, 1'b1, 6'd11);
    frames(1);
    step(1'b0, 1'b0, 1'b1, 6'd1);
    step(1'b0, 1'b0, 1'b1, 6'd2);
    step(1'b0, 1'b0, 1'b1, 6'd3);
    chk("rst.pre_level", 32'(level), 32'd3);
    chk("rst.pre_note",  32'(note),  32'd11);
    ev_valid = 1'b0;
    reset    = 1'b0;
    #1;
    chk_blank("rst");
    chk("rst.rdy", 32'(ev_ready), 32'd1);
    model_reset();
    reset_release();
    frames(1);
    chk_blank("rst.after");

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      step(($urandom % 4) == 0, ($urandom % 97) == 0, ($urandom % 3) != 0,
           6'($urandom_range(0, 63)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
